// File: rtl/mage_lp_iv_gen.sv
// mage_lp_iv_gen: nested-loop iteration-variable generator (odometer).
// Ports: clk_i/rst_i, start_i + config (n_loops_i, ii_i, lp_vars_i),
//   iv_o/valid_o/last_o with ready_i handshake, busy_o, done_o.
module mage_lp_iv_gen #(
   parameter int N_LP       = 4,
   parameter int NBIT_LP_IV = 8,
   parameter int NBIT_II    = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic [$clog2(N_LP):0]          n_loops_i,
   input  logic [NBIT_II-1:0]             ii_i,
   input  logic [N_LP*3*NBIT_LP_IV-1:0]   lp_vars_i,
   output logic [N_LP*NBIT_LP_IV-1:0]     iv_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic                           last_o,
   output logic                           busy_o,
   output logic                           done_o
);

   localparam int NLW = $clog2(N_LP) + 1;
   localparam int W   = NBIT_LP_IV;

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   state_t state, state_n;

   logic [W-1:0]       cnt    [N_LP];
   logic [W-1:0]       cnt_n  [N_LP];
   logic [W-1:0]       iv_r   [N_LP];
   logic [W-1:0]       fv_r   [N_LP];
   logic [W-1:0]       inc_r  [N_LP];
   logic [N_LP-1:0]    act_r;
   logic [N_LP-1:0]    act_in;
   logic [N_LP-1:0]    wrap;
   logic [N_LP:0]      carry;
   logic [NBIT_II-1:0] ii_r;
   logic [NBIT_II-1:0] stall_cnt;
   logic [NLW-1:0]     n_eff;
   logic               done_r;
   logic               last_all;
   logic               hs;

   // Wrap test is done one bit wider so cnt+inc can never alias low.
   always_comb begin
      n_eff = n_loops_i;
      if (n_loops_i == '0)
         n_eff = NLW'(1);
      else if (n_loops_i > NLW'(N_LP))
         n_eff = NLW'(N_LP);
      for (int k = 0; k < N_LP; k++) begin
         act_in[k] = NLW'(k) < n_eff;
         wrap[k] = ({1'b0, cnt[k]} + {1'b0, inc_r[k]}) > {1'b0, fv_r[k]};
         iv_o[k*W +: W] = cnt[k];
      end
   end

   // Odometer: carry enters loop 0 and ripples through wrapping loops.
   always_comb begin
      carry = '0;
      carry[0] = 1'b1;
      for (int k = 0; k < N_LP; k++) begin
         cnt_n[k] = cnt[k];
         if (act_r[k] && carry[k]) begin
            if (wrap[k]) begin
               cnt_n[k]   = iv_r[k];
               carry[k+1] = 1'b1;
            end else begin
               cnt_n[k] = cnt[k] + inc_r[k];
            end
         end
      end
   end

   assign last_all = &(wrap | ~act_r);
   assign valid_o  = (state == RUN);
   assign last_o   = valid_o & last_all;
   assign busy_o   = (state != IDLE);
   assign done_o   = done_r;
   assign hs       = valid_o & ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start_i)
               state_n = RUN;
         end
         RUN: begin
            if (ready_i) begin
               if (last_all)
                  state_n = IDLE;
               else if (ii_r > NBIT_II'(1))
                  state_n = STALL;
            end
         end
         STALL: begin
            if (stall_cnt <= NBIT_II'(1))
               state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < N_LP; k++) begin
            cnt[k]   <= '0;
            iv_r[k]  <= '0;
            fv_r[k]  <= '0;
            inc_r[k] <= '0;
         end
         act_r     <= '0;
         ii_r      <= '0;
         stall_cnt <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= hs & last_all;
         case (state)
            IDLE: begin
               if (start_i) begin
                  act_r <= act_in;
                  ii_r  <= (ii_i == '0) ? NBIT_II'(1) : ii_i;
                  for (int k = 0; k < N_LP; k++) begin
                     iv_r[k]  <= lp_vars_i[k*3*W+2*W +: W];
                     fv_r[k]  <= lp_vars_i[k*3*W+W +: W];
                     inc_r[k] <= (lp_vars_i[k*3*W +: W] == '0) ?
                                 W'(1) : lp_vars_i[k*3*W +: W];
                     cnt[k]   <= act_in[k] ?
                                 lp_vars_i[k*3*W+2*W +: W] : '0;
                  end
               end
            end
            RUN: begin
               if (ready_i && !last_all) begin
                  for (int k = 0; k < N_LP; k++)
                     cnt[k] <= cnt_n[k];
                  stall_cnt <= ii_r - NBIT_II'(1);
               end
            end
            STALL: begin
               stall_cnt <= stall_cnt - NBIT_II'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mage_lp_iv_gen.md
MAGE_LP_IV_GEN -- requirements
Module: mage_lp_iv_gen

Interface
REQ-001 Parameter N_LP, default 4: maximum number of nested loops; loop 0 is innermost.
REQ-002 Parameter NBIT_LP_IV, default 8: width of every iteration-variable, final-value and increment field.
REQ-003 Parameter NBIT_II, default 4: width of the initiation-interval field.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  launch request, sampled only in IDLE.
REQ-007 n_loops_i  in  $clog2(N_LP)+1  number of active loops, sampled with start_i.
REQ-008 ii_i  in  NBIT_II  initiation interval in cycles, sampled with start_i.
REQ-009 lp_vars_i  in  N_LP*3*NBIT_LP_IV  per loop k {iv, fv, inc} (iv MSB side), loop k at slice k, sampled with start_i.
REQ-010 iv_o  out  N_LP*NBIT_LP_IV  current iteration-variable tuple, loop k at slice k.
REQ-011 valid_o  out  1  iv_o holds a valid tuple.
REQ-012 ready_i  in  1  consumer accepts the tuple; handshake = valid_o & ready_i.
REQ-013 last_o  out  1  current tuple is the final one of the nest; qualified by valid_o.
REQ-014 busy_o  out  1  high whenever state is not IDLE.
REQ-015 done_o  out  1  one-cycle pulse after the final handshake.

Function
REQ-016 States: IDLE, RUN, STALL; reset state IDLE.
REQ-017 IDLE & start_i: latch all config, load each active counter with its iv, clear inactive counters to 0, next state RUN.
REQ-018 start_i outside IDLE is ignored; config inputs are don't-care outside the start cycle.
REQ-019 Effective loops = 1 if n_loops_i = 0, N_LP if n_loops_i > N_LP, else n_loops_i.
REQ-020 Effective inc = 1 where latched inc = 0; effective II = 1 where ii_i = 0.
REQ-021 Loop k sequence: iv, iv+inc, ... while value <= fv (unsigned, inclusive); iv > fv yields the single value iv.
REQ-022 Loop k wraps when cnt_k + inc_k > fv_k, computed in NBIT_LP_IV+1 bits (no silent overflow wrap).
REQ-023 Odometer stepping on handshake: loop 0 advances; on wrap it reloads iv and loop 1 advances; carry ripples up to the outermost active loop, all in one cycle.
REQ-024 last_o = valid_o and every active loop at its wrap condition.
REQ-025 RUN: valid_o = 1; iv_o and last_o stable while ready_i = 0 (no tuple drop, no change).
REQ-026 Handshake with last_o = 1: next state IDLE, done_o = 1 for the next cycle only, counters hold.
REQ-027 Handshake, not last, effective II = 1: step counters, stay RUN (one tuple per cycle at full throughput).
REQ-028 Handshake, not last, effective II > 1: step counters, enter STALL with down-counter = II-1; valid_o = 0 in STALL; return to RUN when down-counter reaches 0 after II-1 STALL cycles.
REQ-029 Inactive loop slices of iv_o read 0 at all times after start.
REQ-030 Outputs are registered or derived only from state and counters; no combinational path ready_i -> valid_o.

Reset
REQ-031 rst_i asserted at any time, including mid-nest or in STALL: state IDLE, all counters 0, valid_o=0, last_o=0, busy_o=0, done_o=0, iv_o=0, immediately and asynchronously.
REQ-032 After reset release, no tuple issued until a new start_i in IDLE.

Verification
REQ-033 2 loops, loop0 {0,2,1}, loop1 {0,1,1}, II=1, ready_i=1 -> tuples (l1,l0) 00,01,02,10,11,12 on 6 consecutive cycles, last_o on 12, done_o pulse next cycle.
REQ-034 Same config, ready_i toggling 1/0 -> same 6 tuples, each held stable while ready_i=0, no duplicates.
REQ-035 1 loop {0,6,2}, II=3 -> values 0,2,4,6, valid_o high 1 of every 3 cycles, last_o with 6.
REQ-036 1 loop {250,255,4}, NBIT_LP_IV=8 -> values 250,254 only, last_o on 254 (no overflow to 2).
REQ-037 n_loops_i=0, inc=0, ii_i=0, loop0 {5,7,0} -> treated as 1 loop, inc 1, II 1: values 5,6,7.
REQ-038 rst_i pulsed during STALL of REQ-035 -> all outputs 0 same cycle; new start_i reruns sequence from 0.
